dmem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the 64-bit byte-addressed data memory (64 bytes, little-endian doubleword access).
- Port 0 is the core load/store unit; port 1 is the DMA/program-loader path.
- Grants one transaction at a time with round-robin fairness and drives the memory's MemRead/MemWrite/Mem_Addr/Write_Data.
- Returns registered read data with a fixed 2-cycle latency and flags out-of-range accesses instead of issuing them.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the sequencer state encoding and default access geometry.
package dmem_pkg;

    // Sequencer states: one cycle each, unconditional after a grant.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Default geometry of the attached data memory.
    localparam int DATA_W_DEF    = 64;
    localparam int ADDR_W_DEF    = 64;
    localparam int MEM_BYTES_DEF = 64;

    localparam int BYTES_PER_ACCESS = DATA_W_DEF / 8;
    localparam int MAX_ADDR = MEM_BYTES_DEF - BYTES_PER_ACCESS;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with its rr_last history bit.
// Ports: clk, reset_n, en (grant allowed), req0/req1 in; gnt, gnt_port out.
module rr_arb2 (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt,
    output logic gnt_port
);

    // Resets to 1 so port 0 wins the first tie.
    logic rr_last;

    always_comb begin
        gnt      = en & (req0 | req1);
        gnt_port = 1'b0;
        if (req0 & req1) begin
            gnt_port = ~rr_last;
        end else begin
            gnt_port = req1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= 1'b1;
        end else if (gnt) begin
            rr_last <= gnt_port;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer for two requesters sharing the data memory.
// Ports: req/we/addr/wdata per port in; done per port, rdata, err, busy out;
// mem_addr/mem_wdata/mem_read/mem_write to memory, mem_rdata from memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Highest legal start address; full-width unsigned compare, no wrap.
    localparam logic [ADDR_W-1:0] LAST_OK =
        ADDR_W'(MEM_BYTES - DATA_W / 8);

    state_t state_q;
    state_t state_d;

    logic gnt;
    logic gnt_port;

    logic              cmd_port;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_ok;

    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state_q == IDLE),
        .req0     (req0),
        .req1     (req1),
        .gnt      (gnt),
        .gnt_port (gnt_port)
    );

    assign sel_addr  = gnt_port ? addr1  : addr0;
    assign sel_wdata = gnt_port ? wdata1 : wdata0;
    assign sel_we    = gnt_port ? we1    : we0;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = gnt ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture; requester inputs are ignored after grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_port  <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_ok    <= 1'b0;
        end else if (gnt) begin
            cmd_port  <= gnt_port;
            cmd_we    <= sel_we;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cmd_ok    <= (sel_addr <= LAST_OK);
        end
    end

    // Response capture at the end of ACCESS; held through RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ACCESS) begin
            rdata_q <= (!cmd_we && cmd_ok) ? mem_rdata : '0;
            err_q   <= !cmd_ok;
        end
    end

    // Outputs. Memory address/data come straight from the command
    // registers so they never follow live requester inputs.
    always_comb begin
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        busy      = (state_q != IDLE);
        rdata     = rdata_q;
        err       = err_q;
        unique case (state_q)
            ACCESS: begin
                mem_read  = !cmd_we & cmd_ok;
                mem_write =  cmd_we & cmd_ok;
            end
            RESP: begin
                done0 = !cmd_port;
                done1 =  cmd_port;
            end
            default: ;
        endcase
    end

endmodule
